// File: rtl/led_ctrl.sv
// led_ctrl: drives the 8 board LEDs from register-map fields.
// Each LED picks static, blink, PWM dim or one-shot pulse; the pin value
// is mirrored back as led_sts and one-shot activity as pulse_busy.
`timescale 1ns/1ps
module led_ctrl #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [7:0]  led_value,
  input  logic [15:0] led_mode,
  input  logic [7:0]  blink_half,
  input  logic [7:0]  pwm_duty,
  input  logic [7:0]  pulse_len,
  input  logic [7:0]  pulse_trig,
  output logic [7:0]  led,
  output logic [7:0]  led_sts,
  output logic [7:0]  pulse_busy
);

  localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        tick;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_ph_q, blink_ph_d;
  logic [7:0]  blink_lim;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        pwm_on;
  logic [7:0]  pulse_cnt_q [8];
  logic [7:0]  pulse_cnt_d [8];
  logic [7:0]  pulse_act;
  logic [7:0]  led_q, led_d;
  logic [7:0]  busy_q, busy_d;

  // Time-base: one-cycle tick every TICK_DIV clocks
  always_comb begin
    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
  end

  // Shared blink engine; >= compare lets a shrunk half-period apply at the next tick
  always_comb begin
    blink_lim   = (blink_half == 8'd0) ? 8'd0 : blink_half - 8'd1;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      if (blink_cnt_q >= blink_lim) begin
        blink_cnt_d = 8'd0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Free-running PWM counter; duty 0 never on, 255 on 255/256
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_on    = (pwm_cnt_q < pwm_duty);
  end

  // Per-LED one-shot down counters; trigger load beats a coincident tick
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pulse_cnt_d[i] = pulse_cnt_q[i];
      if (led_mode[2*i +: 2] != 2'b11) begin
        pulse_cnt_d[i] = 8'd0;
      end else if (pulse_trig[i]) begin
        pulse_cnt_d[i] = pulse_len;
      end else if (tick && (pulse_cnt_q[i] != 8'd0)) begin
        pulse_cnt_d[i] = pulse_cnt_q[i] - 8'd1;
      end
      pulse_act[i] = (pulse_cnt_q[i] != 8'd0);
    end
  end

  // Per-LED source select, registered onto the pins
  always_comb begin
    led_d  = 8'd0;
    busy_d = pulse_act;
    for (int i = 0; i < 8; i++) begin
      case (led_mode[2*i +: 2])
        2'b00:   led_d[i] = led_value[i];
        2'b01:   led_d[i] = blink_ph_q;
        2'b10:   led_d[i] = pwm_on;
        default: led_d[i] = pulse_act[i];
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tick_cnt_q  <= 16'd0;
      blink_cnt_q <= 8'd0;
      blink_ph_q  <= 1'b0;
      pwm_cnt_q   <= 8'd0;
      led_q       <= 8'd0;
      busy_q      <= 8'd0;
      for (int i = 0; i < 8; i++) pulse_cnt_q[i] <= 8'd0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 8; i++) pulse_cnt_q[i] <= pulse_cnt_d[i];
    end
  end

  assign led        = led_q;
  assign led_sts    = led_q;
  assign pulse_busy = busy_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with TICK_DIV=4 (ticks take effect on every 4th edge after reset).
`timescale 1ns/1ps
module tb_led_ctrl;

  logic        clk;
  logic        res_n;
  logic [7:0]  led_value;
  logic [15:0] led_mode;
  logic [7:0]  blink_half;
  logic [7:0]  pwm_duty;
  logic [7:0]  pulse_len;
  logic [7:0]  pulse_trig;
  logic [7:0]  led;
  logic [7:0]  led_sts;
  logic [7:0]  pulse_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hi;

  led_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .res_n(res_n), .led_value(led_value), .led_mode(led_mode),
    .blink_half(blink_half), .pwm_duty(pwm_duty), .pulse_len(pulse_len),
    .pulse_trig(pulse_trig), .led(led), .led_sts(led_sts), .pulse_busy(pulse_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  // Assert reset for a few cycles, release 1ns after an edge; cyc counts edges since release
  task automatic do_reset();
    res_n      = 1'b0;
    pulse_trig = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led, 8'h00);
    check("rst_busy", pulse_busy, 8'h00);
    res_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    res_n      = 1'b0;
    led_value  = 8'hA5;
    led_mode   = 16'h0000;
    blink_half = 8'd3;
    pwm_duty   = 8'd0;
    pulse_len  = 8'd5;
    pulse_trig = 8'h00;

    // 1: static mode, reset state and one-clock latency
    do_reset();
    check("rst_sts", led_sts, 8'h00);
    step();
    check("static_a5", led, 8'hA5);
    check("static_sts", led_sts, 8'hA5);
    led_value = 8'h5A;
    #1;
    check("static_hold", led, 8'hA5);
    step();
    check("static_5a", led, 8'h5A);

    // 2: blink on LED0, half=3 -> phase toggles on edges 12,24; then half=1
    led_mode = 16'h0001;
    led_value = 8'h00;
    do_reset();
    step_to(12); check("blink_pre", led[0], 1'b0);
    step_to(13); check("blink_on1", led[0], 1'b1);
    step_to(24); check("blink_hold", led[0], 1'b1);
    step_to(25); check("blink_off1", led[0], 1'b0);
    step_to(29); blink_half = 8'd1;
    step_to(32); check("blink_shr_pre", led[0], 1'b0);
    step_to(33); check("blink_shr_on", led[0], 1'b1);
    step_to(36); check("blink_fast_hold", led[0], 1'b1);
    step_to(37); check("blink_fast_off", led[0], 1'b0);
    step_to(41); check("blink_fast_on", led[0], 1'b1);

    // 3: PWM on LED1, count high cycles over a 256-clk window
    led_mode = 16'h0008;
    begin
      logic [7:0] duties [3];
      int         exp_hi [3];
      duties[0] = 8'd64;  exp_hi[0] = 64;
      duties[1] = 8'd0;   exp_hi[1] = 0;
      duties[2] = 8'd255; exp_hi[2] = 255;
      for (int k = 0; k < 3; k++) begin
        pwm_duty = duties[k];
        step(); step();
        hi = 0;
        for (int j = 0; j < 256; j++) begin
          step();
          hi += int'(led[1]);
        end
        check($sformatf("pwm_duty_%0d", duties[k]), hi, exp_hi[k]);
      end
    end

    // 4: one-shot on LED2, len 5, trigger loads on edge 2
    led_mode   = 16'h0030;
    pulse_len  = 8'd5;
    blink_half = 8'd3;
    do_reset();
    step_to(1); pulse_trig = 8'h04;
    step_to(2); pulse_trig = 8'h00;
    check("pulse_pre", pulse_busy[2], 1'b0);
    step_to(3);
    check("pulse_busy_rise", pulse_busy[2], 1'b1);
    check("pulse_led_rise", led[2], 1'b1);
    step_to(20); check("pulse_busy_last", pulse_busy[2], 1'b1);
    step_to(21);
    check("pulse_busy_fall", pulse_busy[2], 1'b0);
    check("pulse_led_fall", led[2], 1'b0);

    // retrigger landing on the 3rd tick (edge 12): load wins, ends after edge 32
    do_reset();
    step_to(1);  pulse_trig = 8'h04;
    step_to(2);  pulse_trig = 8'h00;
    step_to(11); pulse_trig = 8'h04;
    step_to(12); pulse_trig = 8'h00;
    step_to(21); check("retrig_extended", pulse_busy[2], 1'b1);
    step_to(32); check("retrig_last", pulse_busy[2], 1'b1);
    step_to(33); check("retrig_fall", pulse_busy[2], 1'b0);

    // zero length trigger produces nothing
    pulse_len = 8'd0;
    pulse_trig = 8'h04;
    step();
    pulse_trig = 8'h00;
    step(); check("len0_busy", pulse_busy[2], 1'b0);
    step(); check("len0_led", led[2], 1'b0);

    // 5: LED3 mid-pulse switched to static 0
    led_mode  = 16'h00C0;
    led_value = 8'h00;
    pulse_len = 8'd5;
    do_reset();
    pulse_trig = 8'h08;
    step();
    pulse_trig = 8'h00;
    step_to(6);
    check("mid_busy", pulse_busy[3], 1'b1);
    check("mid_led", led[3], 1'b1);
    led_mode = 16'h0000;
    step(); check("sw_led_1clk", led[3], 1'b0);
    step();
    check("sw_led_2clk", led[3], 1'b0);
    check("sw_busy_2clk", pulse_busy[3], 1'b0);
    pulse_trig = 8'h08;
    step();
    pulse_trig = 8'h00;
    step(); step();
    check("trig_mode0", pulse_busy[3], 1'b0);

    // 6: async reset mid-pulse and mid-blink
    led_mode   = 16'h0031;
    blink_half = 8'd3;
    pulse_len  = 8'd5;
    do_reset();
    step_to(8);  pulse_trig = 8'h04;
    step_to(9);  pulse_trig = 8'h00;
    step_to(15);
    check("pre_rst_blink", led[0], 1'b1);
    check("pre_rst_busy", pulse_busy[2], 1'b1);
    #3;
    res_n = 1'b0;
    #1;
    check("async_led", led, 8'h00);
    check("async_sts", led_sts, 8'h00);
    check("async_busy", pulse_busy, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    res_n = 1'b1;
    cyc   = 0;
    step_to(1);  check("post_busy_1", pulse_busy[2], 1'b0);
    step_to(5);  check("post_busy_5", pulse_busy[2], 1'b0);
    step_to(12);
    check("post_blink_pre", led[0], 1'b0);
    check("post_busy_12", pulse_busy[2], 1'b0);
    step_to(13); check("post_blink_on", led[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Output-side counterpart to the switch/button interrupt controller: drives the 8 board LEDs from register-map fields instead of sampling inputs.
- Each LED independently runs in one of four modes: static, blink, PWM dim or one-shot pulse.
- Per-LED status is exported back to the register map for readback.
- Sits between the register map and the LED pins.

Parameters:
TICK_DIV, 1000, clk cycles per time-base tick; legal range 2..65535.

Ports:
clk            input   1   system clock
res_n          input   1   reset, asynchronous, active-low
led_value      input   8   static level per LED (mode 00)
led_mode       input   16  2 bits per LED, LED i uses [2i+1:2i]; 00 static, 01 blink, 10 PWM, 11 one-shot pulse
blink_half     input   8   blink half-period in ticks; 0 treated as 1
pwm_duty       input   8   PWM on-count out of 256 clk cycles
pulse_len      input   8   one-shot length in ticks
pulse_trig     input   8   per-LED single-cycle trigger strobe (register write pulse)
led            output  8   LED pins, registered
led_sts        output  8   equal to led, for register readback
pulse_busy     output  8   per-LED one-shot active, registered

Behaviour:
- Reset (res_n low, async):
  - led, led_sts, pulse_busy = 0.
  - All counters = 0; blink phase = 0 (off).
- Tick generator:
  - 16-bit counter, 0..TICK_DIV-1.
  - tick = 1 for one clk when count = TICK_DIV-1, then count wraps to 0.
- Blink engine, shared by all mode-01 LEDs:
  - 8-bit counter advances on tick.
  - When counter >= max(blink_half,1)-1 on a tick: counter -> 0 and blink phase toggles. Otherwise counter increments.
  - The >= compare means a reduced blink_half takes effect at the next tick, with no long wrap.
  - The engine runs regardless of mode.
- PWM engine:
  - 8-bit free-running counter, increments every clk and wraps 255 -> 0.
  - pwm_on = (pwm_cnt < pwm_duty).
  - duty 0 = always off; duty 255 = on 255 of every 256 cycles.
- One-shot, per LED i, 8-bit down counter:
  - pulse_trig[i]=1 and mode 11: counter loads pulse_len; a retrigger while busy reloads.
  - pulse_len=0 on trigger: counter stays 0, no pulse.
  - Otherwise counter decrements on tick while nonzero.
  - Trigger and tick in the same cycle: load wins.
  - Mode not 11: counter forced to 0 next cycle, triggers ignored.
  - Pulse active = counter != 0.
- Next-state select per LED i:
  - 00 -> led_value[i]
  - 01 -> blink phase
  - 10 -> pwm_on
  - 11 -> pulse active
- Registering and latency:
  - Selected value is registered into led[i]: one clk latency from any input change to led.
  - pulse_busy[i] is registered from counter != 0, so it rises one clk after the trigger.
  - The trigger cycle loads the counter; led and pulse_busy go high on the following edge; duration is pulse_len ticks, ±1 tick phase.
- Mode change: takes effect one clk later. No glitch beyond one-cycle registered switching.
- Reset mid-pulse or mid-blink: everything returns to reset values immediately. No pulse resumes after reset release.
- All fields are sampled every cycle. No handshake beyond the pulse_trig strobe. A multi-cycle strobe is treated as repeated reloads.

Test Plan:
1. Reset release with TICK_DIV=4, led_mode=0, led_value=8'hA5 -> led=8'h00 during reset; led=8'hA5 exactly 1 clk after led_value applied; led_sts=8'hA5.
2. TICK_DIV=4, LED0 mode 01, blink_half=3 -> led[0] toggles every 12 clk (first toggle at the 3rd tick after reset). Change blink_half to 1 mid-count -> toggle at the next tick, then every 4 clk.
3. LED1 mode 10, pwm_duty=64 -> exactly 64 high cycles per 256-clk window. duty=0 -> never high; duty=255 -> 255 high / 1 low.
4. TICK_DIV=4, LED2 mode 11, pulse_len=5, one pulse_trig[2] strobe -> pulse_busy[2] and led[2] high 1 clk after strobe, for 5 ticks (18..20 clk), then 0. Retrigger at tick 3 -> busy extends 5 ticks from the retrigger. pulse_len=0 -> no pulse.
5. LED3 mode 11 mid-pulse switched to 00 with led_value[3]=0 -> led[3]=0 and pulse_busy[3]=0 within 2 clk. Trigger in mode 00 -> ignored.
6. Assert res_n low mid-pulse and mid-blink -> led, led_sts, pulse_busy = 0 asynchronously. After release, no pulse until a new trigger; blink restarts from phase 0.
